// File: rtl/serialize_word_to_bit_stream.sv
// serialize_word_to_bit_stream: parallel word -> MSB-first serial bit stream for the bit-serial detectors.
// Latency: first bit one cycle after accept; W cycles per word (W+1 with SERIALIZE_WORD_PARITY_EN, appends even parity).
// Backpressure: in_ready only when idle or on the final bit of a word; the serial output has none.

module serialize_word_to_bit_stream #(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_bit,
    output logic             out_valid,
    output logic             busy,
    output logic [CNT_W-1:0] words_sent
);

    localparam int IDX_W = $clog2(W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(W - 1);
`ifndef SERIALIZE_WORD_PARITY_EN
    localparam logic [IDX_W-1:0] PEN_IDX  = IDX_W'(W - 2);
`endif

`ifdef SERIALIZE_WORD_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state;
    state_t           state_nxt;
    logic             load;
    logic             bump;
    logic             rdy_en;
    logic [W-1:0]     shreg;
    logic [IDX_W-1:0] bit_idx;
`ifdef SERIALIZE_WORD_PARITY_EN
    logic             par;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = rdy_en;
                if (in_valid && rdy_en) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_idx == LAST_IDX) begin
`ifdef SERIALIZE_WORD_PARITY_EN
                    state_nxt = PARITY;
`else
                    in_ready = 1'b1;
                    if (in_valid) load = 1'b1;
                    else          state_nxt = IDLE;
`endif
                end
            end
`ifdef SERIALIZE_WORD_PARITY_EN
            PARITY: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Count on the edge that presents the word's final bit, so the count is visible alongside it.
`ifdef SERIALIZE_WORD_PARITY_EN
    assign bump = (state == SHIFT) && (bit_idx == LAST_IDX);
`else
    assign bump = (state == SHIFT) && (bit_idx == PEN_IDX);
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en     <= 1'b0;
            shreg      <= '0;
            bit_idx    <= '0;
            out_bit    <= 1'b0;
            out_valid  <= 1'b0;
            words_sent <= '0;
`ifdef SERIALIZE_WORD_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            rdy_en <= 1'b1;
            if (load) begin
                // shreg holds the not-yet-emitted bits, next one at the MSB
                shreg     <= {in_data[W-2:0], 1'b0};
                out_bit   <= in_data[W-1];
                out_valid <= 1'b1;
                bit_idx   <= '0;
`ifdef SERIALIZE_WORD_PARITY_EN
                par       <= ^in_data;
`endif
            end else if (state_nxt == SHIFT) begin
                shreg     <= {shreg[W-2:0], 1'b0};
                out_bit   <= shreg[W-1];
                out_valid <= 1'b1;
                bit_idx   <= bit_idx + IDX_W'(1);
`ifdef SERIALIZE_WORD_PARITY_EN
            end else if (state_nxt == PARITY) begin
                out_bit   <= par;
                out_valid <= 1'b1;
`endif
            end else begin
                out_bit   <= 1'b0;
                out_valid <= 1'b0;
            end
            if (bump && (words_sent != {CNT_W{1'b1}}))
                words_sent <= words_sent + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_serialize_word_to_bit_stream.sv
// Scoreboard bench for serialize_word_to_bit_stream: accepted words expand to expected serial bits in a queue,
// a negedge monitor pops and compares; CNT_W is narrowed so the saturating counter is reached.

module tb_serialize_word_to_bit_stream;

    localparam int W     = 8;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [W-1:0]     in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             out_bit;
    logic             out_valid;
    logic             busy;
    logic [CNT_W-1:0] words_sent;

    serialize_word_to_bit_stream #(.W(W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_bit    (out_bit),
        .out_valid  (out_valid),
        .busy       (busy),
        .words_sent (words_sent)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    exp_t q[$];
    int   completed = 0;
    int   total = 0;
    int   bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a word becomes W serial bits MSB first, optionally followed by its even parity.
    task automatic push_word(input logic [W-1:0] w);
        logic par_on;
`ifdef SERIALIZE_WORD_PARITY_EN
        par_on = 1'b1;
`else
        par_on = 1'b0;
`endif
        for (int i = W - 1; i >= 0; i--)
            q.push_back('{b: w[i], last: (i == 0) && !par_on});
        if (par_on) begin
            int ones = 0;
            for (int i = 0; i < W; i++) ones += w[i];
            q.push_back('{b: (ones % 2 == 1), last: 1'b1});
        end
    endtask

    // Monitor: every cycle is a sample point since the output has no backpressure.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_outs", {27'd0, out_valid, out_bit, busy, in_ready, |words_sent}, 32'd0);
        end else begin
            logic exp_v;
            exp_v = (q.size() != 0);
            check("out_valid", {31'd0, out_valid}, {31'd0, exp_v});
            check("busy", {31'd0, busy}, {31'd0, exp_v});
            check("in_ready", {31'd0, in_ready}, {31'd0, q.size() <= 1});
            if (exp_v) begin
                exp_t e;
                e = q.pop_front();
                check("out_bit", {31'd0, out_bit}, {31'd0, e.b});
                if (e.last && completed < CMAX) completed++;
            end else begin
                check("idle_bit", {31'd0, out_bit}, 32'd0);
            end
            check("words_sent", {{(32-CNT_W){1'b0}}, words_sent}, completed);
        end
    end

    task automatic drive(input logic v, input logic [W-1:0] d, output logic acc);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        #1 acc = v && in_ready;
        @(posedge clk);
        if (acc) push_word(d);
    endtask

    task automatic send(input logic [W-1:0] w);
        logic acc = 1'b0;
        for (int i = 0; i < 40 && !acc; i++) drive(1'b1, w, acc);
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout: word %0h not accepted within 40 cycles", w);
        end
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) drive(1'b0, W'($urandom), acc);
    endtask

    task automatic drain();
        int k = 0;
        while (q.size() != 0 && k < 100) begin
            idle(1);
            k++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d bits still expected", q.size());
        end
    endtask

    logic [W-1:0] dir_words [4] = '{8'hCC, 8'h33, 8'hA0, 8'hA0};

    initial begin
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        // single word, then back-to-back pair
        idle(1);
        send(dir_words[0]);
        drain();
        idle(1);
        send(dir_words[0]);
        send(dir_words[1]);
        drain();

        // gap of two idle cycles between identical words
        send(dir_words[2]);
        drain();
        idle(2);
        send(dir_words[3]);
        drain();
        idle(1);

        // reset three bits into a word
        send(8'hFF);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        q.delete();
        completed = 0;
        #1;
        check("midreset_valid", {31'd0, out_valid}, 32'd0);
        check("midreset_count", {{(32-CNT_W){1'b0}}, words_sent}, 32'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        idle(5);

        // randomized traffic, enough words to hit counter saturation
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 2) != 0) send(W'($urandom));
            else idle($urandom_range(1, 3));
        end
        drain();
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
